fsm_driver: RTL and testbench

Initiator-side controller for the enable/done worker FSMs used in the core's multi-cycle units. It accepts a single start request and holds the worker in reset while idle. It releases the worker, drives its `en`, and waits for the worker's sticky `done`. It then reports completion with the measured cycle count, or a timeout error if `done` never arrives.

---
 rtl/fsm_driver_if.sv | 30 +++
 rtl/fsm_driver.sv | 160 ++++++++++++++++
 tb/tb_fsm_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fsm_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_driver_if
//  Brief    : Start/ready handshake plus worker enable/done bundle for fsm_driver.
//  Revision : 1.0  initial release
// ============================================================================
interface fsm_driver_if #(
    parameter int CNT_W = 5
) ();
    logic             start;
    logic             ready;
    logic             busy;
    logic             wrk_rst_n;
    logic             en;
    logic             done;
    logic             cmpl;
    logic             err;
    logic [CNT_W-1:0] cycles;

    modport master (
        input  start, done,
        output ready, busy, wrk_rst_n, en, cmpl, err, cycles
    );

    modport slave (
        output start, done,
        input  ready, busy, wrk_rst_n, en, cmpl, err, cycles
    );
endinterface
`default_nettype wire

// File: rtl/fsm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_driver
//  Brief    : Launches one enable/done worker job, measures its RUN length and
//             flags a timeout. FSM_DRIVER_RETRY_EN adds MAX_RETRY re-attempts.
//  Revision : 1.0  initial release
// ============================================================================
module fsm_driver #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 5,
    parameter int MAX_RETRY = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fsm_driver_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    if (TIMEOUT < 2 || TIMEOUT > (1 << CNT_W) - 1 || MAX_RETRY < 0) begin : g_param_check
        $error("fsm_driver: parameter out of range");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] w_cycles_nxt;
    logic             r_ready;
    logic             r_busy;
    logic             r_wrk_rst_n;
    logic             r_en;
    logic             r_cmpl;
    logic             r_err;
    logic             w_ready;
    logic             w_wrk_rst_n;
    logic             w_en;
    logic             w_cmpl;
    logic             w_err;
    logic             w_retry;

`ifdef FSM_DRIVER_RETRY_EN
    localparam int c_RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [c_RTY_W-1:0] r_retry;
    logic               w_retry_clr;
    logic               w_retry_inc;

    // The count is stable from ARM through FAIL, so it can gate err on FAIL entry.
    assign w_retry     = (int'(r_retry) < MAX_RETRY);
    assign w_retry_clr = ((r_state == ST_IDLE) && bus.start) || (r_state == ST_DONE);
    assign w_retry_inc = (r_state == ST_FAIL) && w_retry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry <= '0;
        end else if (w_retry_clr) begin
            r_retry <= '0;
        end else if (w_retry_inc) begin
            r_retry <= r_retry + c_RTY_W'(1);
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cycles_nxt = r_cycles;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            ST_RUN: begin
                // done takes priority over the timeout on the final RUN cycle
                if (bus.done) begin
                    w_state_nxt  = ST_DONE;
                    w_cycles_nxt = r_cnt;
                end else if (r_cnt == c_TIMEOUT) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                if (w_retry) begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        w_ready     = (w_state_nxt == ST_IDLE);
        w_wrk_rst_n = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN) ||
                      (w_state_nxt == ST_DONE);
        w_en        = (w_state_nxt == ST_RUN);
        w_cmpl      = (w_state_nxt == ST_DONE);
        w_err       = (w_state_nxt == ST_FAIL) && !w_retry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cycles    <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_wrk_rst_n <= 1'b0;
            r_en        <= 1'b0;
            r_cmpl      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cycles    <= w_cycles_nxt;
            r_ready     <= w_ready;
            r_busy      <= !w_ready;
            r_wrk_rst_n <= w_wrk_rst_n;
            r_en        <= w_en;
            r_cmpl      <= w_cmpl;
            r_err       <= w_err;
        end
    end

    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.wrk_rst_n = r_wrk_rst_n;
    assign bus.en        = r_en;
    assign bus.cmpl      = r_cmpl;
    assign bus.err       = r_err;
    assign bus.cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_fsm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_driver
//  Brief    : Randomised jobs against a timeline model of fsm_driver behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fsm_driver;

    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = 5;
    localparam int MAX_RETRY = 2;
`ifdef FSM_DRIVER_RETRY_EN
    localparam int ATTEMPTS  = MAX_RETRY + 1;
`else
    localparam int ATTEMPTS  = 1;
`endif
    localparam int NEVER     = 99;

    typedef struct packed {
        logic             ready;
        logic             busy;
        logic             wrk_rst_n;
        logic             en;
        logic             cmpl;
        logic             err;
        logic [CNT_W-1:0] cycles;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fsm_driver_if #(.CNT_W(CNT_W)) bus ();

    fsm_driver #(
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               n_chk  = 0;
    int               n_pass = 0;
    obs_t             exp_q[$];
    logic [CNT_W-1:0] m_cycles;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic obs_t mk(input bit rdy, input bit wr, input bit en, input bit cm, input bit er);
        return {rdy, !rdy, wr, en, cm, er, m_cycles};
    endfunction

    function automatic obs_t sample();
        return {bus.ready, bus.busy, bus.wrk_rst_n, bus.en, bus.cmpl, bus.err, bus.cycles};
    endfunction

    // Expected per-cycle outputs of one job, from the cycle after the start edge
    // up to and including the first IDLE cycle afterwards.
    task automatic build_job(input int tgt[3], output int en_total);
        int run_len;
        bit ok;
        en_total = 0;
        for (int a = 0; a < ATTEMPTS; a++) begin
            ok      = (tgt[a] <= TIMEOUT);
            run_len = ok ? tgt[a] : TIMEOUT;
            exp_q.push_back(mk(0, 1, 0, 0, 0));
            for (int i = 0; i < run_len; i++) exp_q.push_back(mk(0, 1, 1, 0, 0));
            en_total += run_len;
            if (ok) begin
                m_cycles = CNT_W'(tgt[a]);
                exp_q.push_back(mk(0, 1, 0, 1, 0));
                break;
            end
            exp_q.push_back(mk(0, 0, 0, 0, a == ATTEMPTS - 1));
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0));
    endtask

    // Entered during an IDLE cycle; leaves during the IDLE cycle after the job.
    task automatic run_job(input int tgt[3], input bit junk, input bit arm_done);
        int   en_total, en_seen, att, en_cnt, n;
        bit   reached;
        obs_t o, e;
        build_job(tgt, en_total);
        att = 0; en_cnt = 0; reached = 0; en_seen = 0;
        n = exp_q.size();
        bus.start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            check_val("cycle", 32'(o), 32'(e));
            if (o.en) en_seen++;
            // Worker: sticky done after tgt enabled cycles, cleared by its reset.
            if (!o.wrk_rst_n) begin
                if (en_cnt > 0 && att < 2) att++;
                en_cnt  = 0;
                reached = 0;
            end else if (o.en) begin
                en_cnt++;
                if (en_cnt == tgt[att]) reached = 1;
            end
            bus.done  = reached | (arm_done && i == 0);
            bus.start = (junk && i != n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check_val("en_total", 32'(en_seen), 32'(en_total));
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_val("idle", 32'(sample()), 32'(mk(1, 0, 0, 0, 0)));
        end
    endtask

    initial begin
        int t[3];
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.done  = 1'b0;
        m_cycles  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset", 32'(sample()), 32'(mk(1, 0, 0, 0, 0)));
        rst = 1'b0;
        idle(5);

        t = '{5, NEVER, NEVER};       run_job(t, 0, 0);
        t = '{NEVER, NEVER, NEVER};   run_job(t, 0, 0);
        idle(1);
        t = '{7, NEVER, NEVER};       run_job(t, 1, 1);
        t = '{TIMEOUT, NEVER, NEVER}; run_job(t, 0, 0);
        t = '{1, NEVER, NEVER};       run_job(t, 0, 0);
        t = '{NEVER, TIMEOUT, 3};     run_job(t, 1, 0);
        t = '{NEVER, NEVER, 2};       run_job(t, 0, 1);

        for (int j = 0; j < 15; j++) begin
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 3))
                    0:       t[k] = TIMEOUT;
                    1:       t[k] = NEVER;
                    default: t[k] = int'($urandom_range(1, TIMEOUT + 2));
                endcase
            end
            run_job(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        // Abort a job with rst on its 3rd RUN cycle.
        bus.start = 1'b1;
        @(posedge clk); #1;
        check_val("abort_arm", 32'(sample()), 32'(mk(0, 1, 0, 0, 0)));
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("abort_run", 32'(sample()), 32'(mk(0, 1, 1, 0, 0)));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        m_cycles = '0;
        check_val("abort_rst", 32'(sample()), 32'(mk(1, 0, 0, 0, 0)));
        rst = 1'b0;
        idle(3);
        t = '{4, NEVER, NEVER};       run_job(t, 0, 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
